// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Optional feature: define DMEM_ARB_RR_EN for round-robin contention, otherwise port 0 has fixed priority.
`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int size    = 32,
  parameter int MemSize = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            we0,
  input  logic [size-1:0] addr0,
  input  logic [size-1:0] wdata0,
  input  logic            req1,
  input  logic            we1,
  input  logic [size-1:0] addr1,
  input  logic [size-1:0] wdata1,
  output logic            ack0,
  output logic [size-1:0] rdata0,
  output logic            err0,
  output logic            ack1,
  output logic [size-1:0] rdata1,
  output logic            err1,
  output logic [size-1:0] mem_address,
  output logic            mem_read,
  output logic            mem_write,
  output logic [size-1:0] mem_write_data,
  input  logic [size-1:0] mem_read_data,
  output logic            busy,
  output logic            owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  // One extra bit so MemSize == 2**size stays representable.
  localparam logic [size:0] MEM_LIMIT = (size+1)'(MemSize);

  state_t          state_q;
  logic            owner_q, cmd_we_q, cmd_err_q, busy_q;
  logic            mem_read_q, mem_write_q;
  logic            ack0_q, ack1_q, err0_q, err1_q;
  logic [size-1:0] mem_address_q, mem_write_data_q, rdata0_q, rdata1_q;

  logic            grant_d;
  logic            win_we_d;
  logic            win_legal_d;
  logic [size-1:0] win_addr_d, win_wdata_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_d     = 1'b0;
`ifdef DMEM_ARB_RR_EN
    grant_d     = req1 & (~req0 | ~owner_q);
`else
    grant_d     = req1 & ~req0;
`endif
    win_we_d    = grant_d ? we1    : we0;
    win_addr_d  = grant_d ? addr1  : addr0;
    win_wdata_d = grant_d ? wdata1 : wdata0;
    win_legal_d = {1'b0, win_addr_d} < MEM_LIMIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      owner_q          <= 1'b1;
      cmd_we_q         <= 1'b0;
      cmd_err_q        <= 1'b0;
      busy_q           <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      ack0_q           <= 1'b0;
      ack1_q           <= 1'b0;
      err0_q           <= 1'b0;
      err1_q           <= 1'b0;
      rdata0_q         <= '0;
      rdata1_q         <= '0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in the same edge;
      // acks and errs therefore fall back to 0 on every cycle except the one after DONE.
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            owner_q          <= grant_d;
            cmd_we_q         <= win_we_d;
            cmd_err_q        <= ~win_legal_d;
            mem_address_q    <= win_addr_d;
            mem_write_data_q <= win_wdata_d;
            mem_write_q      <= win_we_d & win_legal_d;
            mem_read_q       <= ~win_we_d & win_legal_d;
            busy_q           <= 1'b1;
            state_q          <= ISSUE;
          end
        end
        ISSUE: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          busy_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // The memory registered its read data on the strobe edge; capture it now.
          if (owner_q) begin
            ack1_q   <= 1'b1;
            err1_q   <= cmd_err_q;
            rdata1_q <= (cmd_we_q || cmd_err_q) ? '0 : mem_read_data;
          end else begin
            ack0_q   <= 1'b1;
            err0_q   <= cmd_err_q;
            rdata0_q <= (cmd_we_q || cmd_err_q) ? '0 : mem_read_data;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign err0           = err0_q;
  assign err1           = err1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_write_data = mem_write_data_q;
  assign busy           = busy_q;
  assign owner          = owner_q;

endmodule
